// File: rtl/ps2_keycode_decoder_pkg.sv
// Shared constants and types for the PS/2 keycode decoder.
// Scan-code prefixes, frame-FSM states and default timing.
package ps2_keycode_decoder_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int PS2_FILTER_LEN_DEF = 4;
  localparam int PS2_TIMEOUT_DEF    = 100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  // Odd parity holds when data plus parity has an odd number of ones
  function automatic logic odd_parity_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_keycode_decoder_frame_rx.sv
// PS/2 frame receiver: synchronisers, clock glitch filter,
// 11-bit frame FSM with mid-frame timeout; emits byte + strobe.
module ps2_frame_rx
  import ps2_keycode_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     sclk_q, sclk_d;
  logic [1:0]     sdat_q, sdat_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  frame_state_e   state_q, state_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;

  logic clk_s, dat_s, fall, timeout, frame_end, frame_ok;

  assign clk_s = sclk_q[1];
  assign dat_s = sdat_q[1];

  // Two-flop synchronisers shift the raw pins in
  always_comb begin
    sclk_d = {sclk_q[0], ps2_clk};
    sdat_d = {sdat_q[0], ps2_data};
  end

  // Glitch filter: flip only after FILTER_LEN differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d = clk_s;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Timeout counts idle cycles while a frame is in flight
  always_comb begin
    tmo_d   = '0;
    timeout = 1'b0;
    if (state_q != ST_IDLE && !fall) begin
      if (tmo_q == TCNT_LAST) begin
        timeout = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  // Frame FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (fall && !dat_s) state_d = ST_DATA;
      ST_DATA:   if (fall && bcnt_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (fall) state_d = ST_PARITY == state_q ? ST_STOP : state_q;
      ST_STOP:   if (fall) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  // Datapath: shift data bits LSB first, capture parity bit
  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    if (timeout) begin
      shift_d = '0;
      bcnt_d  = '0;
    end else if (fall) begin
      if (state_q == ST_IDLE) begin
        bcnt_d = '0;
      end else if (state_q == ST_DATA) begin
        shift_d = {dat_s, shift_q[7:1]};
        bcnt_d  = bcnt_q + 1'b1;
      end else if (state_q == ST_PARITY) begin
        par_d = dat_s;
      end
    end
  end

  // Frame FSM outputs: judge the frame on the stop-bit edge
  always_comb begin
    frame_end  = fall && (state_q == ST_STOP);
    frame_ok   = dat_s && odd_parity_ok(shift_q, par_q);
    byte_valid = frame_end && frame_ok;
    frame_err  = frame_end && !frame_ok;
    rx_byte    = shift_q;
  end

  // State register; lines idle high so synchronisers reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= 2'b11;
      sdat_q  <= 2'b11;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
      tmo_q   <= '0;
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      tmo_q   <= tmo_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// PS/2 set-2 scan-code decoder: held-key level plus make code.
// Define PS2_EXT_FILTER_EN to swallow E0-prefixed codes.
module ps2_keycode_decoder
  import ps2_keycode_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       keypress,
  output logic [7:0] keycode
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       keypress_q, keypress_d;
  logic [7:0] keycode_q, keycode_d;
  logic       is_ext, is_brk, swallow;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign is_ext = (rx_byte == PS2_EXT);
  assign is_brk = (rx_byte == PS2_BREAK);

`ifdef PS2_EXT_FILTER_EN
  assign swallow = ext_q;
`else
  assign swallow = 1'b0;
`endif

  // Scan-code layer: prefixes arm flags, other bytes act on the key
  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    keypress_d = keypress_q;
    keycode_d  = keycode_q;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      unique case (1'b1)
        is_ext: ext_d = 1'b1;
        is_brk: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!swallow) begin
            if (!brk_q) begin
              keycode_d  = rx_byte;
              keypress_d = 1'b1;
            end else if (rx_byte == keycode_q) begin
              keypress_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Key state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      keypress_q <= 1'b0;
      keycode_q  <= 8'h00;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      keypress_q <= keypress_d;
      keycode_q  <= keycode_d;
    end
  end

  assign keypress = keypress_q;
  assign keycode  = keycode_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Self-checking bench for ps2_keycode_decoder.
// Random frames checked against a scan-code reference model.
module tb_ps2_keycode_decoder;

  localparam int FLEN = 4;
  localparam int TMO  = 200;
`ifdef PS2_EXT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       keypress;
  logic [7:0] keycode;

  int n_cmp = 0;
  int n_bad = 0;
  int hp = 8;

  logic [7:0] m_code;
  logic       m_press;
  bit         m_ext, m_brk;
  logic [8:0] post [FLEN+4];

  always #5 clk = ~clk;

  ps2_keycode_decoder #(
    .FILTER_LEN     (FLEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keypress (keypress),
    .keycode  (keycode)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_press = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
  endtask

  // Reference: what a keyboard byte means for the held key
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!(FILT && m_ext)) begin
        if (!m_brk) begin
          m_code = b; m_press = 1'b1;
        end else if (b == m_code) begin
          m_press = 1'b0;
        end
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    ps2_data = b;
    tick(hp / 2);
    if (glitch) begin
      ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1;
    end
    tick(hp - hp / 2);
    ps2_clk = 1'b0;
    tick(hp / 2);
    if (glitch) begin
      ps2_clk = 1'b1; tick(1); ps2_clk = 1'b0;
    end
    tick(hp - hp / 2);
    ps2_clk = 1'b1;
  endtask

  // Full frame; outputs after the stop-bit edge land in post[]
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit glitch);
    logic [7:0] d;
    d = b;
    drive_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    drive_bit((~^d) ^ bad_par, glitch);
    ps2_data = ~bad_stop;
    tick(hp);
    ps2_clk = 1'b0;
    for (int i = 0; i < FLEN + 4; i++) begin
      tick(1);
      post[i] = {keypress, keycode};
    end
    tick(hp - (FLEN + 4));
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(2 * hp);
    model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    tick(3);
    n_cmp++;
    if (keypress !== 1'b0) begin
      n_bad++; $display("FAIL reset_keypress: got %b want 0", keypress);
    end
    n_cmp++;
    if (keycode !== 8'h00) begin
      n_bad++; $display("FAIL reset_keycode: got %h want 00", keycode);
    end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_make_break();
    send_frame(8'h1C, 0, 0, 0);
    n_cmp++;
    if (post[FLEN+3] !== {1'b1, 8'h1C}) begin
      n_bad++;
      $display("FAIL make_latency: got %h want 11c", post[FLEN+3]);
    end
    send_frame(8'hF0, 0, 0, 0);
    n_cmp++;
    if (keypress !== 1'b1) begin
      n_bad++; $display("FAIL break_prefix_only: got %b want 1", keypress);
    end
    send_frame(8'h1C, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b0, 8'h1C}) begin
      n_bad++;
      $display("FAIL break_1c: got %b/%h want 0/1c", keypress, keycode);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b0, 8'h1C}) begin
      n_bad++;
      $display("FAIL bad_parity: got %b/%h want 0/1c", keypress, keycode);
    end
    send_frame(8'h15, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b1, 8'h15}) begin
      n_bad++;
      $display("FAIL after_parity: got %b/%h want 1/15", keypress, keycode);
    end
  endtask

  task automatic test_last_key();
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'h1B, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b1, 8'h1B}) begin
      n_bad++;
      $display("FAIL last_make: got %b/%h want 1/1b", keypress, keycode);
    end
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b1, 8'h1B}) begin
      n_bad++;
      $display("FAIL other_break: got %b/%h want 1/1b", keypress, keycode);
    end
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1B, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b0, 8'h1B}) begin
      n_bad++;
      $display("FAIL cur_break: got %b/%h want 0/1b", keypress, keycode);
    end
  endtask

  task automatic test_timeout();
    drive_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 0);
    tick(TMO + 1);
    send_frame(8'h2D, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b1, 8'h2D}) begin
      n_bad++;
      $display("FAIL timeout: got %b/%h want 1/2d", keypress, keycode);
    end
  endtask

  task automatic test_glitch();
    send_frame(8'h5A, 0, 0, 1);
    n_cmp++;
    if ({keypress, keycode} !== {1'b1, 8'h5A}) begin
      n_bad++;
      $display("FAIL glitch: got %b/%h want 1/5a", keypress, keycode);
    end
  endtask

  task automatic test_ext();
    logic [8:0] want;
    logic [7:0] prev;
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h5A, 0, 0, 0);
    prev = keycode;
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h14, 0, 0, 0);
    want = FILT ? {1'b0, prev} : {1'b1, 8'h14};
    n_cmp++;
    if ({keypress, keycode} !== want) begin
      n_bad++;
      $display("FAIL ext_make: got %b/%h want %b/%h",
               keypress, keycode, want[8], want[7:0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] keys [6];
    logic [7:0] b;
    int r;
    keys[0] = 8'h1C; keys[1] = 8'h1B; keys[2] = 8'h15;
    keys[3] = 8'h2D; keys[4] = 8'h5A; keys[5] = 8'h14;
    for (int n = 0; n < 70; n++) begin
      hp = 8 + $urandom_range(0, 4);
      r = $urandom_range(0, 9);
      b = (r < 2) ? 8'hF0 : (r == 2) ? 8'hE0 : keys[$urandom_range(0, 5)];
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                 $urandom_range(0, 3) == 0);
      n_cmp++;
      if ({keypress, keycode} !== {m_press, m_code}) begin
        n_bad++;
        $display("FAIL random[%0d] byte %h: got %b/%h want %b/%h",
                 n, b, keypress, keycode, m_press, m_code);
      end
    end
    hp = 8;
  endtask

  task automatic test_reset_mid();
    drive_bit(1'b0, 0);
    drive_bit(1'b1, 0);
    drive_bit(1'b0, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({keypress, keycode} !== 9'h000) begin
      n_bad++;
      $display("FAIL async_reset: got %b/%h want 0/00", keypress, keycode);
    end
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(2 * hp);
    send_frame(8'h33, 0, 0, 0);
    n_cmp++;
    if ({keypress, keycode} !== {1'b1, 8'h33}) begin
      n_bad++;
      $display("FAIL after_reset: got %b/%h want 1/33", keypress, keycode);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_parity();
    test_last_key();
    test_timeout();
    test_glitch();
    test_ext();
    test_random();
    if (keycode == 8'h00) send_frame(8'h1C, 0, 0, 0);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
